// File: rtl/mult_pkg.sv
// Shared widths for the fast-multiplier family.
package mult_pkg;
  localparam int OPW   = 4;
  localparam int PRODW = 8;
endpackage

// File: rtl/full_adder.sv
// Shared arithmetic library: one-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/half_adder.sv
// Shared arithmetic library: one-bit half adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/multiplier_4bits_v7.sv
// Unsigned 4x4 Dadda multiplier: AND array, two carry-save stages,
// a 6-bit ripple adder and a registered 8-bit product.
module multiplier_4bits_v7
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   A,
  input  logic [OPW-1:0]   B,
  output logic [PRODW-1:0] product
);

  // pp[i][j] carries weight 2^(i+j)
  logic [OPW-1:0][OPW-1:0] pp;

  for (genvar i = 0; i < OPW; i++) begin : g_row
    for (genvar j = 0; j < OPW; j++) begin : g_col
      assign pp[i][j] = A[j] & B[i];
    end
  end

  logic s1_s3, s1_c3, s1_s4, s1_c4;

  // Stage 1: columns 3 and 4 trimmed to height 3
  half_adder u_s1_ha3 (.a(pp[0][3]), .b(pp[1][2]), .sum(s1_s3), .carry(s1_c3));
  half_adder u_s1_ha4 (.a(pp[1][3]), .b(pp[2][2]), .sum(s1_s4), .carry(s1_c4));

  logic s2_s2, s2_c2, s2_s3, s2_c3, s2_s4, s2_c4, s2_s5, s2_c5;

  // Stage 2: columns 2..5 trimmed to height 2, carries rippling into column 6
  half_adder u_s2_ha2 (.a(pp[0][2]), .b(pp[1][1]), .sum(s2_s2), .carry(s2_c2));
  full_adder u_s2_fa3 (.a(pp[2][1]), .b(pp[3][0]), .cin(s1_s3), .sum(s2_s3), .cout(s2_c3));
  full_adder u_s2_fa4 (.a(pp[3][1]), .b(s1_c3),    .cin(s1_s4), .sum(s2_s4), .cout(s2_c4));
  full_adder u_s2_fa5 (.a(pp[2][3]), .b(pp[3][2]), .cin(s1_c4), .sum(s2_s5), .cout(s2_c5));

  logic [6:1]       rx, ry;
  logic [7:2]       rc;
  logic [PRODW-1:0] sum_d;

  assign rx = {pp[3][3], s2_s5, s2_s4, s2_s3, pp[2][0], pp[0][1]};
  assign ry = {s2_c5,    s2_c4, s2_c3, s2_c2, s2_s2,    pp[1][0]};

  assign sum_d[0] = pp[0][0];

  half_adder u_cpa1 (.a(rx[1]), .b(ry[1]), .sum(sum_d[1]), .carry(rc[2]));

  for (genvar k = 2; k <= 6; k++) begin : g_cpa
    full_adder u_fa (.a(rx[k]), .b(ry[k]), .cin(rc[k]), .sum(sum_d[k]), .cout(rc[k+1]));
  end

  assign sum_d[7] = rc[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) product <= '0;
    else        product <= sum_d;
  end

endmodule

// File: tb/tb_multiplier_4bits_v7.sv
// Scoreboard bench for multiplier_4bits_v7: driver queues expected products,
// monitor compares one cycle later.
module tb_multiplier_4bits_v7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B;
  logic [7:0] product;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;

  multiplier_4bits_v7 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .product(product)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] exp);
    checks++;
    if (product === exp) passes++;
    else $display("[TB] FAIL %s: product=%0d expected=%0d", name, product, exp);
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    expQ.push_back('{name, exp});
  endtask

  // Monitor: the product registered at each edge is checked just after it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.name, e.exp);
    end
  end

  initial begin
    rst_n = 1'b1;
    A     = 4'd15;
    B     = 4'd15;

    #1 rst_n = 1'b0;
    #1 checkOutput("reset_async", 8'd0);
    repeat (3) begin
      @(posedge clk);
      #1 checkOutput("reset_hold", 8'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back('{"reset_release", 8'd225});

    applyStimulus("dir_0x0",   4'd0,  4'd0,  8'd0);
    applyStimulus("dir_2x3",   4'd2,  4'd3,  8'd6);
    applyStimulus("dir_10x3",  4'd10, 4'd3,  8'd30);
    applyStimulus("dir_13x10", 4'd13, 4'd10, 8'd130);

    applyStimulus("bnd_15x15", 4'd15, 4'd15, 8'd225);
    applyStimulus("bnd_15x1",  4'd15, 4'd1,  8'd15);
    applyStimulus("bnd_1x15",  4'd1,  4'd15, 8'd15);
    applyStimulus("bnd_8x8",   4'd8,  4'd8,  8'd64);
    applyStimulus("bnd_15x0",  4'd15, 4'd0,  8'd0);

    applyStimulus("b2b_1x1", 4'd1, 4'd1, 8'd1);
    applyStimulus("b2b_2x2", 4'd2, 4'd2, 8'd4);
    applyStimulus("b2b_3x3", 4'd3, 4'd3, 8'd9);
    applyStimulus("b2b_4x4", 4'd4, 4'd4, 8'd16);

    // Reset lands between edges, so the pending 13x10 is never captured
    @(negedge clk);
    A = 4'd13;
    B = 4'd10;
    #2 rst_n = 1'b0;
    #1 checkOutput("midreset_async", 8'd0);
    @(posedge clk);
    #1 checkOutput("midreset_hold", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expQ.push_back('{"midreset_release", 8'd130});

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus($sformatf("exh_%0dx%0d", a, b), a[3:0], b[3:0], 8'(a * b));
      end
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
